// File: rtl/shift_load_sequencer.sv
// shift_load_sequencer
// Serialises a stream of N-bit words through a 74194-style universal shift
// register. Each accepted word is parallel-loaded and then shifted N-1
// times on pixel clock enables, either left-fed or right-fed depending on
// the flip bit latched with the word. When a load is due and no word is
// available, or on flush, the register is cleared so the video path shows
// blank pixels.
module shift_load_sequencer #(
    parameter int   N    = 4,
    parameter logic FILL = 1'b0
) (
    input  logic         mclk,
    input  logic         clr_n,
    input  logic         cen,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         in_flip,
    output logic         in_ready,
    output logic [1:0]   sr_S,
    output logic [N-1:0] sr_D,
    output logic         sr_clr,
    output logic         sr_L,
    output logic         sr_R,
    output logic         busy,
    output logic         underrun,
    output logic [7:0]   urun_cnt
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dir;
    logic          ld_due;
    logic          cnt_zero;

    // Underrun counter holds at its maximum rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign sr_D     = in_data;
    assign sr_L     = FILL;
    assign sr_R     = FILL;
    assign cnt_zero = (cnt == '0);
    assign ld_due   = (state == IDLE) || ((state == SHIFT) && cnt_zero);

    // Shift register control for the current cycle; the register only acts on enabled edges.
    always_comb begin
        sr_S     = 2'b00;
        sr_clr   = ~clr_n;
        in_ready = 1'b0;
        if (clr_n && cen) begin
            if (flush) begin
                sr_clr = 1'b1;
            end else if (ld_due && in_valid) begin
                sr_S     = 2'b11;
                in_ready = 1'b1;
            end else if ((state == SHIFT) && cnt_zero) begin
                // Word exhausted with nothing queued: blank the output.
                sr_clr = 1'b1;
            end else if (state == SHIFT) begin
                sr_S = dir ? 2'b10 : 2'b01;
            end
        end
    end

    // Sequencer state, shift count, latched direction and underrun status.
    always_ff @(posedge mclk) begin
        if (!clr_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dir      <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
            urun_cnt <= 8'd0;
        end else begin
            underrun <= 1'b0;
            if (cen) begin
                if (flush) begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else if (ld_due && in_valid) begin
                    state <= SHIFT;
                    cnt   <= CNT_LOAD;
                    dir   <= in_flip;
                    busy  <= 1'b1;
                end else if ((state == SHIFT) && cnt_zero) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    underrun <= 1'b1;
                    urun_cnt <= sat_inc(urun_cnt);
                end else if (state == SHIFT) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/shift_load_sequencer.md
Name: shift_load_sequencer

Overview:
- Controller that drives an N-bit 74194-style universal shift register (S, D, clr, L/R) to serialise a stream of parallel words.
- Sits between a tile/sprite fetch stage (valid/ready source) and the pixel shift register in the video path.
- Each word is parallel-loaded, then shifted N-1 times at the pixel clock enable, in a per-word direction (normal/flip).
- Blanks the register on underrun or flush.

Parameters:
- N, 4, register width and pixels per word; legal range N >= 2.
- FILL, 1'b0, constant bit driven on sr_L and sr_R (fill shifted into vacated positions).
- CW, $clog2(N), pixel counter width; derived, not overridden.

Ports:
- mclk        in   1   main clock
- clr_n       in   1   synchronous reset, active-low
- cen         in   1   pixel clock enable; all state advances only when cen=1
- flush       in   1   abort current word; sampled only when cen=1
- in_valid    in   1   source has a word
- in_data     in   N   word to load
- in_flip     in   1   direction for this word: 0 = feed-from-right mode (S=01), 1 = feed-from-left mode (S=10)
- in_ready    out  1   word accepted this cycle (combinational)
- sr_S        out  2   mode select to shift register (combinational)
- sr_D        out  N   parallel data to shift register; equals in_data
- sr_clr      out  1   active-high clear to shift register (combinational)
- sr_L        out  1   left feed; equals FILL
- sr_R        out  1   right feed; equals FILL
- busy        out  1   state == SHIFT (registered)
- underrun    out  1   one-mclk pulse when a load was due and no word was available (registered)
- urun_cnt    out  8   saturating underrun count (registered)

Behaviour:
- Reset (clr_n=0 at a mclk edge): state=IDLE, cnt=0, dir=0, busy=0, underrun=0, urun_cnt=0. sr_clr=1 combinationally whenever clr_n=0, regardless of cen.
- Reset has priority over all other events, including mid-word. The cycle after reset is released, the block is IDLE.
- States: IDLE, SHIFT. cnt holds the number of shifts remaining in the current word.
- Load condition: ld_due = (state==IDLE) | (state==SHIFT & cnt==0).
- When cen=0: sr_S=00, sr_clr=~clr_n, in_ready=0; no state, counter, or status change. underrun still returns to 0.
- When cen=1, evaluated in priority order:
  1. flush=1: sr_clr=1, sr_S=00, in_ready=0, state->IDLE, cnt->0. No underrun counted.
  2. ld_due & in_valid: sr_S=11, in_ready=1, state->SHIFT, cnt->N-1, dir->in_flip. Back-to-back loads produce no gap pixel.
  3. SHIFT & cnt==0 & ~in_valid: sr_clr=1 (blank), sr_S=00, state->IDLE, underrun->1, urun_cnt saturating increment (stays at 255).
  4. IDLE & ~in_valid: sr_S=00, no change, no underrun.
  5. SHIFT & cnt>0: sr_S = dir ? 10 : 01, cnt->cnt-1.
- underrun is high for exactly one mclk cycle following the edge where case 3 occurred.
- in_ready never asserts when cen=0. A word is accepted only on (in_valid & in_ready) at an mclk edge.
- in_data/in_flip are don't-care when not accepted.
- Per word: exactly 1 load edge + N-1 shift edges. Steady-state throughput is one word per N cen ticks.
- Direction latched at load; changes to in_flip mid-word have no effect.
- sr_D, sr_L, sr_R are pure wiring. Outputs are glitch-insensitive: the register samples them only on enabled mclk edges.

Test Plan:
- Reset: hold clr_n=0 for 3 cycles with in_valid=1, cen=1 -> sr_clr=1, in_ready=0, busy=0, urun_cnt=0 throughout. First cen tick after release loads (sr_S=11).
- Continuous stream, N=4, cen=1 every cycle, in_valid=1, words A,B with flip=0 -> sr_S sequence 11,01,01,01,11,01,01,01; in_ready high on cycles 0 and 4 only; attached lmn74194_nbit emits A[3],A[2],A[1],A[0],B[3]...
- cen every 3rd cycle, one word with flip=1 -> sr_S=11 then 10,10,10 only on cen cycles, 00 otherwise. The word completes after 12 mclk cycles; in_ready pulses only on a cen cycle.
- Underrun: single word, then in_valid=0 -> on 5th cen tick sr_clr=1, underrun one-cycle pulse, urun_cnt=1, state IDLE. Further idle ticks do not increment urun_cnt.
- Flush at cnt=2 with in_valid=1 -> sr_clr=1, in_ready=0, no underrun. The next cen tick loads the pending word.
- Saturation: force 260 underruns -> urun_cnt stops at 255. Then clr_n=0 mid-word (cnt=1) -> counter 0, IDLE next cycle.
